// File: rtl/usb_crc_tx_if.sv
// Byte-stream handshake into the USB CRC serializer: payload byte, framing
// (tx_last / last_bits) and the tx_valid/tx_ready acceptance pair.
interface usb_crc_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic [2:0] last_bits;
  logic       tx_ready;

  modport master (output tx_data, tx_valid, tx_last, last_bits, input tx_ready);
  modport slave  (input tx_data, tx_valid, tx_last, last_bits, output tx_ready);
endinterface

// File: rtl/usb_crc_tx.sv
// USB packet serializer: shifts payload bits LSB first, then a CRC5/CRC16 remainder MSB first.
// USB_CRC_COMPLIANT_EN: all-ones CRC preset and complemented CRC on the wire; default is zero preset, true remainder.
module usb_crc_tx (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         shift_enable,
  input  logic         tx_start,
  input  logic         crc_sel,
  usb_crc_tx_if.slave  bus,
  output logic         tx_bit,
  output logic         tx_bit_valid,
  output logic         busy,
  output logic         tx_done
);

`ifdef USB_CRC_COMPLIANT_EN
  localparam logic [15:0] CRC_PRESET = 16'hFFFF;
  localparam logic [15:0] CRC_XOROUT = 16'hFFFF;
`else
  localparam logic [15:0] CRC_PRESET = 16'h0000;
  localparam logic [15:0] CRC_XOROUT = 16'h0000;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, DATA, CRC, DONE} state_t;

  state_t      state, state_nx;
  logic        sel_q;
  logic        last_q;
  logic [7:0]  byte_sr;
  logic [3:0]  bit_cnt;
  logic [15:0] crc_q, crc_nx;
  logic [15:0] crc_sr;
  logic [4:0]  crc_cnt;

  // One CRC step on the bit about to leave; CRC5 lives in crc_q[4:0].
  function automatic logic [15:0] crc_step(input logic sel, input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = '0;
    if (sel) begin
      r = {c[14:0], 1'b0};
      if (b ^ c[15]) r = r ^ 16'h8005;
    end else begin
      r[4:0] = {c[3:0], 1'b0};
      if (b ^ c[4]) r[4:0] = r[4:0] ^ 5'h05;
    end
    return r;
  endfunction

  assign crc_nx       = crc_step(sel_q, crc_q, byte_sr[0]);
  assign bus.tx_ready = (state == LOAD);
  assign busy         = (state != IDLE);
  assign tx_done      = (state == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (tx_start) state_nx = LOAD;
      LOAD: if (bus.tx_valid) state_nx = DATA;
      DATA: if (shift_enable && bit_cnt == 4'd1) state_nx = last_q ? CRC : LOAD;
      CRC:  if (shift_enable && crc_cnt == 5'd0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sel_q        <= 1'b0;
      last_q       <= 1'b0;
      byte_sr      <= '0;
      bit_cnt      <= '0;
      crc_q        <= '0;
      crc_sr       <= '0;
      crc_cnt      <= '0;
      tx_bit       <= 1'b0;
      tx_bit_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tx_start) begin
          crc_q <= CRC_PRESET;
          sel_q <= crc_sel;
        end
        LOAD: begin
          // A strobe landing in the accept cycle is consumed by the load, not emitted.
          if (bus.tx_valid) begin
            byte_sr <= bus.tx_data;
            last_q  <= bus.tx_last;
            bit_cnt <= (bus.tx_last && bus.last_bits != 3'd0) ? {1'b0, bus.last_bits} : 4'd8;
          end else begin
            tx_bit_valid <= 1'b0;
          end
        end
        DATA: if (shift_enable) begin
          tx_bit       <= byte_sr[0];
          tx_bit_valid <= 1'b1;
          byte_sr      <= {1'b0, byte_sr[7:1]};
          crc_q        <= crc_nx;
          bit_cnt      <= bit_cnt - 4'd1;
          // Freeze the remainder left-aligned so the CRC phase always shifts from bit 15.
          if (bit_cnt == 4'd1 && last_q) begin
            crc_sr  <= sel_q ? (crc_nx ^ CRC_XOROUT) : {crc_nx[4:0] ^ CRC_XOROUT[4:0], 11'd0};
            crc_cnt <= sel_q ? 5'd16 : 5'd5;
          end
        end
        CRC: if (shift_enable) begin
          if (crc_cnt == 5'd0) begin
            tx_bit_valid <= 1'b0;
          end else begin
            tx_bit       <= crc_sr[15];
            tx_bit_valid <= 1'b1;
            crc_sr       <= {crc_sr[14:0], 1'b0};
            crc_cnt      <= crc_cnt - 5'd1;
          end
        end
        DONE: tx_bit_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/usb_crc_tx.md
USB_CRC_TX -- requirements
Module: usb_crc_tx

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: n_rst  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: shift_enable  in  1  one-cycle bit-time strobe; advances serializer by one bit.
REQ-004 SHALL have port: tx_start  in  1  one-cycle pulse; begins packet, samples crc_sel.
REQ-005 SHALL have port: crc_sel  in  1  0 = CRC5 (x^5+x^2+1), 1 = CRC16 (x^16+x^15+x^2+1).
REQ-006 SHALL have port: tx_data  in  8  payload byte, LSB transmitted first.
REQ-007 SHALL have port: tx_valid  in  1  tx_data valid.
REQ-008 SHALL have port: tx_last  in  1  current byte is the final payload byte.
REQ-009 SHALL have port: last_bits  in  3  valid bits in the final byte, 1-7; 0 means 8.
REQ-010 SHALL have port: tx_ready  out  1  byte accepted when tx_valid && tx_ready.
REQ-011 SHALL have port: tx_bit  out  1  serial output bit, registered.
REQ-012 SHALL have port: tx_bit_valid  out  1  tx_bit carries packet data or CRC.
REQ-013 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port: tx_done  out  1  one-cycle pulse after the last CRC bit.

Function
REQ-015 SHALL implement states IDLE, LOAD, DATA, CRC, DONE.
REQ-016 IDLE: tx_start -> LOAD; clear CRC register; latch crc_sel. All other inputs ignored.
REQ-017 LOAD: tx_ready = 1. Accepted byte -> DATA; store byte, tx_last, and bit count (8, or last_bits when tx_last). No byte -> stall; shift_enable ignored; tx_bit_valid = 0.
REQ-018 DATA: each shift_enable drives the next stored bit onto tx_bit, sets tx_bit_valid, and feeds the bit to the selected CRC.
REQ-019 CRC update per bit: inv = bit ^ crc_msb; crc = (crc << 1) ^ (inv ? poly : 0). poly = 5'h05 (CRC5) or 16'h8005 (CRC16).
REQ-020 After the final bit of a byte: non-last byte -> LOAD; last byte -> CRC.
REQ-021 CRC: the remainder (5 or 16 bits) is frozen on entry and shifted out MSB first, one bit per shift_enable.
REQ-022 After the final CRC bit: -> DONE. DONE asserts tx_done for one cycle, then -> IDLE.
REQ-023 Without shift_enable, tx_bit and tx_bit_valid SHALL hold their values. tx_bit_valid falls on entry to DONE.
REQ-024 tx_start outside IDLE SHALL be ignored.
REQ-025 With REQ-017 stall semantics, tx_bit_valid drops while waiting in LOAD and reasserts on the next emitted bit.
REQ-026 If tx_valid and shift_enable fall in the same LOAD cycle, the byte SHALL be accepted; that strobe does not emit a bit.

Reset
REQ-027 n_rst low SHALL asynchronously force: state IDLE, CRC register 0, tx_ready 0, tx_bit 0, tx_bit_valid 0, busy 0, tx_done 0.
REQ-028 Reset mid-packet SHALL abandon the packet. No tx_done is produced for it.

Configuration
REQ-029 Macro USB_CRC_COMPLIANT_EN SHALL control CRC preset and output polarity.
REQ-030 With USB_CRC_COMPLIANT_EN defined: CRC register presets to all ones at tx_start, and the transmitted CRC is the bitwise complement of the remainder.
REQ-031 Without USB_CRC_COMPLIANT_EN: preset is all zeros and the remainder is sent uncomplemented. This matches the team receive-side CRC generator.

Verification (macro undefined unless stated)
REQ-032 CRC16, single byte 0x01 with tx_last -> serial 1,0,0,0,0,0,0,0, then CRC 0x8303 MSB first; 24 valid bits; one tx_done pulse.
REQ-033 CRC5, bytes 0x01 then 0x00 with tx_last, last_bits = 3 -> 11 data bits (1, then ten 0s), then 1,1,1,1,1 (CRC 0x1F).
REQ-034 CRC16 two-byte packet with tx_valid withheld 5 shift_enables between bytes -> tx_bit_valid low during the gap, and the CRC matches the gap-free run.
REQ-035 n_rst pulsed after 4 data bits -> all outputs 0 immediately. A new tx_start then yields a correct full packet.
REQ-036 USB_CRC_COMPLIANT_EN defined, CRC5 payload of 11 zero bits -> the transmitted CRC equals the complement of the all-ones-preset remainder (checked against a reference model).
REQ-037 tx_start asserted mid-packet -> no effect on the bit stream or the CRC.
